ps2_frame_receiver: RTL and testbench

Upstream front end of the keyboard path. Synchronises and glitch-filters the raw ps2Clk/ps2Data pins and deserialises 11-bit PS/2 device-to-host frames into bytes. Folds E0/F0 prefixes into a single key event (code, break, extended) consumed by kbdController to produce opCode. Runs entirely in the pixelClk domain.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_input_filter.sv | 70 +++++++
 rtl/ps2_frame_receiver.sv | 182 ++++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Definitions shared by the PS/2 receive path: the receive FSM state
// encoding, the scan-code prefix bytes and the frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

  // Odd parity: data bits and parity bit together hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// ps2_input_filter
// Brings the raw PS/2 pins into the clock domain, removes short glitches
// from the PS/2 clock and flags its falling edges.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   fall_edge  out  one-cycle pulse when the filtered clock goes 1->0
//   data_sync  out  synchronised PS/2 data level
module ps2_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_edge,
  output logic data_sync
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_chain;
  logic [SYNC_STAGES-1:0] data_chain;
  logic [CNT_W-1:0]       stable_cnt;
  logic                   clk_f;
  logic                   clk_f_d;
  logic                   clk_s;

  assign clk_s = clk_chain[SYNC_STAGES-1];

  // Chains start at 1 so a reset does not look like a bus transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_chain  <= '1;
      data_chain <= '1;
    end else begin
      clk_chain  <= {clk_chain[SYNC_STAGES-2:0], ps2_clk};
      data_chain <= {data_chain[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // The filtered level follows only after FILTER_LEN consecutive cycles of
  // disagreement; any agreeing cycle restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_f      <= 1'b1;
      clk_f_d    <= 1'b1;
      stable_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s != clk_f) begin
        if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
          clk_f      <= clk_s;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  assign fall_edge = clk_f_d & ~clk_f;
  assign data_sync = data_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
// Receives 11-bit PS/2 device-to-host frames, checks odd parity and the
// stop bit, and folds E0/F0 prefixes into single key events.
// Ports:
//   clock        in   pixel clock, rising edge
//   reset        in   synchronous, active-high
//   ps2Clk       in   raw PS/2 clock pin
//   ps2Data      in   raw PS/2 data pin
//   rxByte       out  last correctly received byte
//   rxValid      out  one-cycle pulse, rxByte updated
//   rxError      out  one-cycle pulse, parity/stop/timeout failure
//   keyCode      out  scan code of the last key event
//   keyValid     out  one-cycle pulse, key event ready (one cycle after rxValid)
//   keyBreak     out  event was a release
//   keyExtended  out  event was extended
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT     = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxError,
  output logic [7:0] keyCode,
  output logic       keyValid,
  output logic       keyBreak,
  output logic       keyExtended
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic fall_edge;
  logic data_s;

  ps2_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .fall_edge(fall_edge),
    .data_sync(data_s)
  );

  ps2_state_t  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q;
  logic        timeout_hit;
  logic        frame_ok;
  logic        frame_err;

  logic [7:0]  rx_byte_q;
  logic        rx_valid_q;
  logic        rx_error_q;
  logic [7:0]  key_code_q;
  logic        key_valid_q;
  logic        key_break_q;
  logic        key_ext_q;
  logic        ext_pend_q;
  logic        brk_pend_q;

  assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
    end
  end

  // Timeout wins over a coincident fall edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    if (timeout_hit) begin
      state_d   = ST_IDLE;
      frame_err = 1'b1;
    end else if (fall_edge) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_s && odd_parity_ok(shift_q, parity_q)) frame_ok = 1'b1;
          else frame_err = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (fall_edge || state_q == ST_IDLE) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Byte-level outputs register the frame verdict; key decode then looks at
  // the registered byte, giving keyValid exactly one cycle after rxValid.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_break_q <= 1'b0;
      key_ext_q   <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
    end else begin
      rx_valid_q  <= frame_ok;
      rx_error_q  <= frame_err;
      key_valid_q <= 1'b0;
      if (frame_ok) rx_byte_q <= shift_q;
      if (rx_error_q) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (rx_valid_q) begin
        if (rx_byte_q == PS2_PREFIX_EXT) begin
          ext_pend_q <= 1'b1;
        end else if (rx_byte_q == PS2_PREFIX_BRK) begin
          brk_pend_q <= 1'b1;
        end else begin
          key_valid_q <= 1'b1;
          key_code_q  <= rx_byte_q;
          key_break_q <= brk_pend_q;
          key_ext_q   <= ext_pend_q;
          ext_pend_q  <= 1'b0;
          brk_pend_q  <= 1'b0;
        end
      end
    end
  end

  assign rxByte      = rx_byte_q;
  assign rxValid     = rx_valid_q;
  assign rxError     = rx_error_q;
  assign keyCode     = key_code_q;
  assign keyValid    = key_valid_q;
  assign keyBreak    = key_break_q;
  assign keyExtended = key_ext_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: the stimulus side pushes expected
// byte and key events from a frame-level model; a monitor pops and compares
// whenever the DUT pulses rxValid/rxError/keyValid.
module tb_ps2_frame_receiver;

  localparam int HALF       = 40;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 500;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxError;
  logic [7:0] keyCode;
  logic       keyValid;
  logic       keyBreak;
  logic       keyExtended;

  ps2_frame_receiver #(
    .SYNC_STAGES(2),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .rxByte     (rxByte),
    .rxValid    (rxValid),
    .rxError    (rxError),
    .keyCode    (keyCode),
    .keyValid   (keyValid),
    .keyBreak   (keyBreak),
    .keyExtended(keyExtended)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } rx_ev_t;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } key_ev_t;

  rx_ev_t  rx_q[$];
  key_ev_t key_q[$];

  int tests = 0;
  int fails = 0;

  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] m_last = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
  endtask

  // Frame-level reference: a good byte updates the last byte and either
  // records a prefix or yields a key event; any failure clears the prefixes.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (ok) begin
      rx_q.push_back('{err: 1'b0, b: b});
      m_last = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        key_q.push_back('{code: b, brk: m_brk, ext: m_ext});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else begin
      rx_q.push_back('{err: 1'b1, b: m_last});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Drives bits LSB first; data changes mid-high, sampled on the falling edge.
  // The glitch option puts a sub-filter high pulse inside bit 3's low phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2Data = bits[i];
      wait_cycles(HALF / 2);
      ps2Clk = 1'b0;
      if (glitch && i == 3) begin
        wait_cycles(10);
        ps2Clk = 1'b1;
        wait_cycles(FILTER_LEN - 1);
        ps2Clk = 1'b0;
        wait_cycles(HALF - 10 - (FILTER_LEN - 1));
      end else begin
        wait_cycles(HALF);
      end
      ps2Clk = 1'b1;
      wait_cycles(HALF / 2);
    end
    ps2Data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
    logic par;
    par = (~^b) ^ bad_par;
    model_frame(b, !bad_par && stop);
    send_bits({stop, par, b, 1'b0}, 11, glitch);
    wait_cycles(HALF);
  endtask

  // Monitor
  logic       prev_valid = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      logic exp_key;
      if (rxValid || rxError) begin
        if (rx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rx actual valid=%0b error=%0b byte=%0h required no event at %0t",
                   rxValid, rxError, rxByte, $time);
        end else begin
          rx_ev_t ev;
          ev = rx_q.pop_front();
          check("rx_error_flag", 32'(rxError), 32'(ev.err));
          check("rx_valid_flag", 32'(rxValid), 32'(!ev.err));
          check("rx_byte", 32'(rxByte), 32'(ev.b));
        end
      end
      exp_key = prev_valid && prev_byte != 8'hE0 && prev_byte != 8'hF0;
      if (keyValid || exp_key) begin
        check("key_lag", 32'(keyValid), 32'(exp_key));
        if (keyValid) begin
          if (key_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_key actual code=%0h required no event at %0t", keyCode, $time);
          end else begin
            key_ev_t k;
            k = key_q.pop_front();
            check("key_code", 32'(keyCode), 32'(k.code));
            check("key_break", 32'(keyBreak), 32'(k.brk));
            check("key_extended", 32'(keyExtended), 32'(k.ext));
          end
        end
      end
      prev_valid = rxValid;
      prev_byte  = rxByte;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rxByte"}, 32'(rxByte), 32'h0);
    check({tag, "_rxValid"}, 32'(rxValid), 32'h0);
    check({tag, "_rxError"}, 32'(rxError), 32'h0);
    check({tag, "_keyCode"}, 32'(keyCode), 32'h0);
    check({tag, "_keyValid"}, 32'(keyValid), 32'h0);
    check({tag, "_keyBreak"}, 32'(keyBreak), 32'h0);
    check({tag, "_keyExtended"}, 32'(keyExtended), 32'h0);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    bit bad_par, bad_stop, glitch;

    wait_cycles(5);
    @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;
    wait_cycles(20);

    // plain key
    send_frame(8'h1C, 0, 1, 0);
    // break prefix
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    // extended break, then a plain key shows the flags were cleared
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h75, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    // parity error, stop error, recovery
    send_frame(8'h1C, 1, 1, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'h29, 0, 1, 0);
    // an error drops a pending prefix
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'h33, 1, 1, 0);
    send_frame(8'h34, 0, 1, 0);

    // timeout: start + 4 data bits, then idle bus
    model_frame(8'h00, 0);
    send_bits(11'b000_0000_1010, 5, 0);
    wait_cycles(TIMEOUT + 100);
    send_frame(8'h5A, 0, 1, 0);

    // short low glitch on an idle bus
    ps2Clk = 1'b0;
    wait_cycles(3);
    ps2Clk = 1'b1;
    wait_cycles(50);
    // short high glitch inside a bit's low phase
    send_frame(8'h3A, 0, 1, 1);

    // reset in the middle of a frame
    send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 6, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_last = 8'h00;
    wait_cycles(3);
    @(negedge clock);
    check_outputs_zero("midreset");
    @(posedge clock);
    #1 reset = 1'b0;
    wait_cycles(20);
    send_frame(8'h1C, 0, 1, 0);

    // randomized frames, weighted toward prefixes and faults
    for (int n = 0; n < 28; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      bad_par  = (r == 0);
      bad_stop = (r == 1);
      glitch   = ($urandom_range(0, 3) == 0);
      send_frame(b, bad_par, !bad_stop, glitch);
    end

    wait_cycles(200);
    check("rx_queue_drained", 32'(rx_q.size()), 32'h0);
    check("key_queue_drained", 32'(key_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
